// File: rtl/dual_issue_queue_pkg.sv
// Shared types and constants for the dual-issue instruction queue.
//   ISSUE_* : issue_method encodings driven to the hazard unit
//   issue_pd_t : pre-decoded facts about one instruction
//   iq_entry_t : one queue slot (instruction word + PC)
//   dual_ok()  : pairing rules for issuing alpha and beta together
package dual_issue_queue_pkg;

  localparam int NUM_LANES = 2;  // lane 0 = alpha (head), lane 1 = beta (head+1)

  localparam logic [1:0] ISSUE_NONE   = 2'd0;
  localparam logic [1:0] ISSUE_SINGLE = 2'd1;
  localparam logic [1:0] ISSUE_DUAL   = 2'd2;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_COP0    = 6'h10;

  typedef struct packed {
    logic [4:0] dest;       // written GPR, 0 = none
    logic       rs_used;
    logic       rt_used;
    logic       is_jb;      // jump or branch (has a delay slot)
    logic       is_mem;     // load or store
    logic       is_serial;  // HI/LO, CP0, trap or reserved: never in beta
  } issue_pd_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } iq_entry_t;

  // True when beta may issue in the same cycle as alpha.
  function automatic logic dual_ok(input issue_pd_t a, input issue_pd_t b,
                                   input logic [4:0] b_rs, input logic [4:0] b_rt);
    logic raw, waw;
    raw = (a.dest != 5'd0) &&
          ((b.rs_used && (b_rs == a.dest)) || (b.rt_used && (b_rt == a.dest)));
    waw = (a.dest != 5'd0) && (b.dest == a.dest);
    return !b.is_jb && !raw && !waw && !(a.is_mem && b.is_mem) && !b.is_serial;
  endfunction

endpackage

// File: rtl/dual_issue_queue_if.sv
// Fetch -> queue -> decode/hazard bundle.
//   master : fetch + hazard unit side (drives pushes, flush, stalls)
//   slave  : the queue (drives in_ready, alpha/beta, issue_method, count)
interface dual_issue_queue_if #(parameter int ADDR_W = 4);
  logic             flush;
  logic             in_valid;
  logic [1:0]       in_cnt;
  logic [31:0]      in_inst0, in_inst1;
  logic [31:0]      in_pc0, in_pc1;
  logic             in_ready;
  logic             fifo_wait;
  logic             stall_d;
  logic [31:0]      alpha_inst, alpha_pc;
  logic             alpha_valid;
  logic [31:0]      beta_inst, beta_pc;
  logic             beta_valid;
  logic [1:0]       issue_method;
  logic [ADDR_W:0]  count;

  modport master (
    output flush, in_valid, in_cnt, in_inst0, in_inst1, in_pc0, in_pc1,
           fifo_wait, stall_d,
    input  in_ready, alpha_inst, alpha_pc, alpha_valid,
           beta_inst, beta_pc, beta_valid, issue_method, count
  );

  modport slave (
    input  flush, in_valid, in_cnt, in_inst0, in_inst1, in_pc0, in_pc1,
           fifo_wait, stall_d,
    output in_ready, alpha_inst, alpha_pc, alpha_valid,
           beta_inst, beta_pc, beta_valid, issue_method, count
  );
endinterface

// File: rtl/dual_issue_queue_predecode.sv
// issue_predecode: MIPS32 instruction word -> issue_pd_t.
//   inst : instruction word
//   pd   : dest register, source usage, jump/branch, memory, serialising flags
// Anything not recognised is flagged serial so it never pairs as beta.
module issue_predecode
  import dual_issue_queue_pkg::*;
(
  input  logic [31:0] inst,
  output issue_pd_t   pd
);
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign funct = inst[5:0];

  always_comb begin
    pd = '0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          6'h00, 6'h02, 6'h03: begin pd.rt_used = 1'b1; pd.dest = rd; end
          6'h04, 6'h06, 6'h07: begin pd.rs_used = 1'b1; pd.rt_used = 1'b1; pd.dest = rd; end
          6'h08: begin pd.is_jb = 1'b1; pd.rs_used = 1'b1; end
          6'h09: begin pd.is_jb = 1'b1; pd.rs_used = 1'b1; pd.dest = rd; end
          6'h0C, 6'h0D: pd.is_serial = 1'b1;
          6'h10, 6'h12: begin pd.is_serial = 1'b1; pd.dest = rd; end
          6'h11, 6'h13: begin pd.is_serial = 1'b1; pd.rs_used = 1'b1; end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            pd.is_serial = 1'b1; pd.rs_used = 1'b1; pd.rt_used = 1'b1;
          end
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            pd.rs_used = 1'b1; pd.rt_used = 1'b1; pd.dest = rd;
          end
          default: pd.is_serial = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          5'h00, 5'h01: begin pd.is_jb = 1'b1; pd.rs_used = 1'b1; end
          5'h10, 5'h11: begin pd.is_jb = 1'b1; pd.rs_used = 1'b1; pd.dest = 5'd31; end
          default: pd.is_serial = 1'b1;
        endcase
      end
      OP_J:   pd.is_jb = 1'b1;
      OP_JAL: begin pd.is_jb = 1'b1; pd.dest = 5'd31; end
      OP_BEQ, OP_BNE: begin pd.is_jb = 1'b1; pd.rs_used = 1'b1; pd.rt_used = 1'b1; end
      OP_BLEZ, OP_BGTZ: begin pd.is_jb = 1'b1; pd.rs_used = 1'b1; end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
        pd.rs_used = 1'b1; pd.dest = rt;
      end
      6'h0F: pd.dest = rt;  // lui
      OP_COP0: begin
        pd.is_serial = 1'b1;
        if (inst == 32'h4200_0018) pd.dest = 5'd0;  // eret
        else if (rs == 5'h00)      pd.dest = rt;    // mfc0
        else if (rs == 5'h04)      pd.rt_used = 1'b1;  // mtc0
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        pd.is_mem = 1'b1; pd.rs_used = 1'b1; pd.dest = rt;
      end
      6'h28, 6'h29, 6'h2B: begin
        pd.is_mem = 1'b1; pd.rs_used = 1'b1; pd.rt_used = 1'b1;
      end
      default: pd.is_serial = 1'b1;
    endcase
  end
endmodule

// File: rtl/dual_issue_queue.sv
// dual_issue_queue: instruction buffer between fetch and decode.
//   clk, reset : single clock, asynchronous active-high reset
//   iq (slave) : up to 2 pushes/cycle from fetch; alpha/beta head view,
//                issue_method (0/1/2) and count to the hazard unit.
// Head entries are read combinationally and pre-decoded each cycle; the
// number popped equals the issue_method driven out.
module dual_issue_queue
  import dual_issue_queue_pkg::*;
#(
  parameter int DEPTH = 16
)(
  input logic             clk,
  input logic             reset,
  dual_issue_queue_if.slave iq
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  iq_entry_t mem [DEPTH];

  logic [ADDR_W-1:0] rd_ptr, wr_ptr, wr_ptr_p1;
  logic [CNT_W-1:0]  count;
  logic              in_ready, do_push;
  logic [1:0]        n_push, n_pop, cand, issue;

  logic [NUM_LANES-1:0][31:0] rd_inst, rd_pc;
  issue_pd_t                  pd [NUM_LANES];

  // Lane l views entry rd_ptr+l; stale slots beyond count are masked by the
  // count checks below, so no valid bits are kept per entry.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [ADDR_W-1:0] ra;
    assign ra         = rd_ptr + ADDR_W'(l);
    assign rd_inst[l] = mem[ra].inst;
    assign rd_pc[l]   = mem[ra].pc;
    issue_predecode u_pd (.inst(rd_inst[l]), .pd(pd[l]));
  end

  // Alpha's source usage and serial flag do not affect pairing.
  logic unused_pd;
  assign unused_pd = ^{pd[0].rs_used, pd[0].rt_used, pd[0].is_serial};

  always_comb begin
    cand = ISSUE_SINGLE;
    if (count == '0)
      cand = ISSUE_NONE;
    else if (pd[0].is_jb && (count < CNT_W'(2)))
      cand = ISSUE_NONE;  // hold the branch until its delay slot arrives
    else if ((count >= CNT_W'(2)) &&
             dual_ok(pd[0], pd[1], rd_inst[1][25:21], rd_inst[1][20:16]))
      cand = ISSUE_DUAL;
  end

  assign issue    = (iq.fifo_wait | iq.stall_d) ? ISSUE_NONE : cand;
  assign n_pop    = issue;
  assign in_ready = (count <= CNT_W'(DEPTH - 2));
  assign do_push  = iq.in_valid & in_ready & ~iq.flush;
  // in_cnt 3 is illegal; it is treated as 2 rather than left undefined.
  assign n_push   = !do_push    ? 2'd0 :
                    iq.in_cnt[1] ? 2'd2 : {1'b0, iq.in_cnt[0]};
  assign wr_ptr_p1 = wr_ptr + ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (iq.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + ADDR_W'(n_pop);
      wr_ptr <= wr_ptr + ADDR_W'(n_push);
      count  <= count + CNT_W'(n_push) - CNT_W'(n_pop);
    end
  end

  // Storage needs no reset: occupancy is carried entirely by count.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[wr_ptr]    <= '{inst: iq.in_inst0, pc: iq.in_pc0};
    if (n_push == 2'd2) mem[wr_ptr_p1] <= '{inst: iq.in_inst1, pc: iq.in_pc1};
  end

  assign iq.in_ready     = in_ready;
  assign iq.issue_method = issue;
  assign iq.count        = count;
  assign iq.alpha_inst   = rd_inst[0];
  assign iq.alpha_pc     = rd_pc[0];
  assign iq.alpha_valid  = (count != '0);
  assign iq.beta_inst    = rd_inst[1];
  assign iq.beta_pc      = rd_pc[1];
  assign iq.beta_valid   = (count >= CNT_W'(2)) && (issue == ISSUE_DUAL);
endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed bench for dual_issue_queue: hand-computed expectations checked
// with immediate assertions after each step.
module tb_dual_issue_queue;
  logic clk, reset;
  int checks = 0;
  int errors = 0;

  dual_issue_queue_if #(.ADDR_W(4)) iq ();
  dual_issue_queue #(.DEPTH(16)) dut (.clk(clk), .reset(reset), .iq(iq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addu(input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h21};
  endfunction
  function automatic logic [31:0] lw(input int rt, input int rs);
    return {6'h23, 5'(rs), 5'(rt), 16'd0};
  endfunction
  function automatic logic [31:0] sw(input int rt, input int rs);
    return {6'h2B, 5'(rs), 5'(rt), 16'd0};
  endfunction
  function automatic logic [31:0] beq(input int rs, input int rt);
    return {6'h04, 5'(rs), 5'(rt), 16'd1};
  endfunction
  function automatic logic [31:0] mult(input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 10'd0, 6'h18};
  endfunction
  // Independent stream: even/odd entries write $8/$9 and read only $1/$2.
  function automatic logic [31:0] fill_inst(input int k);
    return addu(8 + (k & 1), 1, 2);
  endfunction
  function automatic logic [31:0] fill_pc(input int k);
    return 32'h1000 + 32'(4 * k);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push2(input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1);
    iq.in_valid = 1'b1; iq.in_cnt = 2'd2;
    iq.in_inst0 = i0; iq.in_pc0 = p0; iq.in_inst1 = i1; iq.in_pc1 = p1;
  endtask
  task automatic push1(input logic [31:0] i0, input logic [31:0] p0);
    iq.in_valid = 1'b1; iq.in_cnt = 2'd1;
    iq.in_inst0 = i0; iq.in_pc0 = p0; iq.in_inst1 = '0; iq.in_pc1 = '0;
  endtask
  task automatic idle();
    iq.in_valid = 1'b0;
  endtask
  task automatic push_fill_pair(input int j);
    push2(fill_inst(2*j), fill_pc(2*j), fill_inst(2*j+1), fill_pc(2*j+1));
  endtask

  // Push a pair into an empty queue, check the issue decision, then flush.
  task automatic pair_chk(input string tag, input logic [31:0] i0,
                          input logic [31:0] i1, input logic [1:0] exp);
    push2(i0, 32'h500, i1, 32'h504);
    step(); idle(); #1;
    chk(tag, iq.issue_method, exp);
    iq.flush = 1'b1;
    step(); iq.flush = 1'b0; #1;
    chk({tag, "_flushed"}, iq.count, 0);
  endtask

  initial begin
    reset = 1'b1;
    iq.flush = 1'b0; iq.in_valid = 1'b0; iq.in_cnt = 2'd0;
    iq.in_inst0 = '0; iq.in_inst1 = '0; iq.in_pc0 = '0; iq.in_pc1 = '0;
    iq.fifo_wait = 1'b0; iq.stall_d = 1'b0;
    step(); step();
    chk("rst_count", iq.count, 0);
    chk("rst_in_ready", iq.in_ready, 1);
    chk("rst_method", iq.issue_method, 0);
    chk("rst_alpha_valid", iq.alpha_valid, 0);
    chk("rst_beta_valid", iq.beta_valid, 0);
    reset = 1'b0;

    // Two independent addu -> dual issue, then empty.
    push2(addu(1, 2, 3), 32'h100, addu(4, 5, 6), 32'h104);
    step(); idle(); #1;
    chk("ind_method", iq.issue_method, 2);
    chk("ind_count", iq.count, 2);
    chk("ind_alpha_pc", iq.alpha_pc, 32'h100);
    chk("ind_beta_pc", iq.beta_pc, 32'h104);
    chk("ind_beta_valid", iq.beta_valid, 1);
    step();
    chk("ind_drained", iq.count, 0);

    // RAW: second addu reads $1 -> single, then dependent op alone.
    push2(addu(1, 2, 3), 32'h200, addu(2, 1, 3), 32'h204);
    step(); idle(); #1;
    chk("raw_method", iq.issue_method, 1);
    chk("raw_beta_valid", iq.beta_valid, 0);
    step();
    chk("raw_count", iq.count, 1);
    chk("raw_alpha_pc", iq.alpha_pc, 32'h204);
    chk("raw_method2", iq.issue_method, 1);
    step();
    chk("raw_drained", iq.count, 0);

    // Branch waits for its delay slot.
    push1(beq(4, 5), 32'h300);
    step(); idle(); #1;
    chk("br_alone_count", iq.count, 1);
    chk("br_alone_method", iq.issue_method, 0);
    chk("br_alone_avalid", iq.alpha_valid, 1);
    push1(addu(6, 7, 8), 32'h304);
    step(); idle(); #1;
    chk("br_pair_method", iq.issue_method, 2);
    chk("br_alpha_inst", iq.alpha_inst, beq(4, 5));
    chk("br_beta_inst", iq.beta_inst, addu(6, 7, 8));
    step();
    chk("br_drained", iq.count, 0);

    // jal with a slot reading $31 -> single; slot issues alone next.
    push2({6'h03, 26'h40}, 32'h400, addu(2, 31, 0), 32'h404);
    step(); idle(); #1;
    chk("jal_method", iq.issue_method, 1);
    step();
    chk("jal_slot_pc", iq.alpha_pc, 32'h404);
    chk("jal_slot_method", iq.issue_method, 1);
    step();

    pair_chk("two_mem", lw(8, 1), sw(9, 2), 2'd1);
    pair_chk("waw", addu(5, 1, 2), addu(5, 3, 4), 2'd1);
    pair_chk("beta_mult", addu(5, 1, 2), mult(3, 4), 2'd1);
    pair_chk("raw_base", addu(5, 1, 2), lw(6, 5), 2'd1);
    pair_chk("beta_br", addu(5, 1, 2), beq(1, 2), 2'd1);
    pair_chk("one_mem", lw(8, 1), addu(9, 1, 2), 2'd2);
    pair_chk("dest_zero", addu(0, 1, 2), addu(3, 0, 0), 2'd2);

    // Fill from an empty, pointer-zero queue; exercise full and wrap.
    iq.stall_d = 1'b1;
    for (int j = 0; j < 7; j++) begin
      push_fill_pair(j);
      step();
    end
    idle(); #1;
    chk("fill14_count", iq.count, 14);
    chk("fill14_ready", iq.in_ready, 1);
    chk("fill14_method", iq.issue_method, 0);
    push_fill_pair(7);
    step(); idle(); #1;
    chk("full_count", iq.count, 16);
    chk("full_ready", iq.in_ready, 0);
    push2(addu(3, 1, 2), 32'hDEAD0, addu(4, 1, 2), 32'hDEAD4);
    step(); idle(); #1;
    chk("drop_count", iq.count, 16);
    iq.stall_d = 1'b0; #1;
    chk("full_method", iq.issue_method, 2);
    step();
    chk("pop_count", iq.count, 14);
    chk("pop_alpha_pc", iq.alpha_pc, fill_pc(2));
    push_fill_pair(8);
    #1;
    chk("pushpop_ready", iq.in_ready, 1);
    step(); idle(); #1;
    chk("pushpop_count", iq.count, 14);
    chk("pushpop_alpha_pc", iq.alpha_pc, fill_pc(4));
    repeat (6) step();
    chk("wrap_count", iq.count, 2);
    chk("wrap_alpha_pc", iq.alpha_pc, fill_pc(16));
    chk("wrap_beta_pc", iq.beta_pc, fill_pc(17));
    chk("wrap_method", iq.issue_method, 2);
    step();
    chk("wrap_drained", iq.count, 0);

    // fifo_wait holds the head for three cycles.
    iq.fifo_wait = 1'b1;
    push_fill_pair(0); step();
    push_fill_pair(1); step();
    idle(); #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("wait_count_%0d", c), iq.count, 4);
      chk($sformatf("wait_method_%0d", c), iq.issue_method, 0);
      if (c < 2) step();
    end
    iq.fifo_wait = 1'b0; #1;
    chk("wait_release", iq.issue_method, 2);
    step();
    chk("wait_pop", iq.count, 2);
    step();
    chk("wait_drained", iq.count, 0);

    // Flush with a simultaneous push at count 6.
    iq.stall_d = 1'b1;
    for (int j = 0; j < 3; j++) begin
      push_fill_pair(j);
      step();
    end
    idle(); #1;
    chk("pre_flush_count", iq.count, 6);
    push_fill_pair(3);
    iq.flush = 1'b1;
    step(); iq.flush = 1'b0; idle(); #1;
    chk("flush_count", iq.count, 0);
    chk("flush_avalid", iq.alpha_valid, 0);
    iq.stall_d = 1'b0;

    // Asynchronous reset between clock edges.
    push_fill_pair(0);
    step(); idle(); #1;
    chk("pre_arst_method", iq.issue_method, 2);
    reset = 1'b1; #1;
    chk("arst_count", iq.count, 0);
    chk("arst_method", iq.issue_method, 0);
    chk("arst_avalid", iq.alpha_valid, 0);
    chk("arst_bvalid", iq.beta_valid, 0);
    chk("arst_ready", iq.in_ready, 1);
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
